// File: rtl/pl_iter.sv
// Iterative five-lane diffusion engine. It processes LANES_PER_CYCLE lanes per clock and holds the result under a valid/ready handshake.
// Optional feature: define PL_ITER_LANE_MASK_EN to add a per-lane pass-through mask (lane_mask_i).
module pl_iter #(
    parameter int LANES_PER_CYCLE = 1
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [319:0] state_i,
`ifdef PL_ITER_LANE_MASK_EN
    input  logic [4:0]   lane_mask_i,
`endif
    output logic         valid_o,
    input  logic         ready_i,
    output logic [319:0] diffusion_o,
    output logic         busy_o
);

    // Out-of-range settings are pulled into 1..5 so the index arithmetic stays bounded.
    localparam int LPC = (LANES_PER_CYCLE < 1) ? 1 :
                         (LANES_PER_CYCLE > 5) ? 5 : LANES_PER_CYCLE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4:0][63:0]       r_work;
    logic [4:0][63:0]       w_work_nxt;
    logic [2:0]             r_idx;
    logic [2:0]             w_idx_nxt;
    logic [3:0]             w_lo;
    logic [3:0]             w_hi;
    logic [3:0]             w_sum;
    logic                   w_last;
    logic                   w_accept;
    logic [4:0]             w_mask;

    function automatic logic [63:0] f_rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] f_diffuse(input int k, input logic [63:0] x);
        logic [63:0] y;
        case (k)
            0:       y = x ^ f_rotr(x, 19) ^ f_rotr(x, 28);
            1:       y = x ^ f_rotr(x, 61) ^ f_rotr(x, 39);
            2:       y = x ^ f_rotr(x, 1)  ^ f_rotr(x, 6);
            3:       y = x ^ f_rotr(x, 10) ^ f_rotr(x, 17);
            default: y = x ^ f_rotr(x, 7)  ^ f_rotr(x, 41);
        endcase
        return y;
    endfunction

    assign w_accept = (r_state == S_IDLE) && valid_i;
    assign w_lo     = {1'b0, r_idx};
    assign w_hi     = w_lo + 4'(LPC - 1);
    assign w_sum    = w_lo + 4'(LPC);
    assign w_last   = (w_hi >= 4'd4);
    // The index saturates at lane 4 so the last group is clipped instead of wrapping.
    assign w_idx_nxt = (w_sum > 4'd4) ? 3'd4 : w_sum[2:0];

`ifdef PL_ITER_LANE_MASK_EN
    logic [4:0] r_mask;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_mask <= 5'h1F;
        end else if (w_accept) begin
            r_mask <= lane_mask_i;
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = 5'h1F;
`endif

    always_comb begin
        w_work_nxt = r_work;
        for (int k = 0; k < 5; k++) begin
            if ((4'(k) >= w_lo) && (4'(k) <= w_hi) && w_mask[k]) begin
                w_work_nxt[k] = f_diffuse(k, r_work[k]);
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready_o     = 1'b0;
        valid_o     = 1'b0;
        busy_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
                if (ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_work <= '0;
            r_idx  <= 3'd0;
        end else if (w_accept) begin
            r_work <= state_i;
            r_idx  <= 3'd0;
        end else if (r_state == S_RUN) begin
            r_work <= w_work_nxt;
            r_idx  <= w_idx_nxt;
        end
    end

    assign diffusion_o = r_work;

endmodule

// File: tb/tb_pl_iter.sv
// Directed bench for pl_iter: three instances (1, 5 and 2 lanes per cycle) checked against hand values and a lane model.
// The mask scenario is compiled in when PL_ITER_LANE_MASK_EN is defined.
module tb_pl_iter;

    logic         clk = 1'b0;
    logic         resetb;
    logic         vin  [3];
    logic         rin  [3];
    logic [319:0] sti  [3];
    logic [4:0]   mski [3];
    logic         rdy  [3];
    logic         vo   [3];
    logic         bsy  [3];
    logic [319:0] dif  [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pl_iter #(.LANES_PER_CYCLE(1)) u_l1 (
        .clock_i(clk), .resetb_i(resetb), .valid_i(vin[0]), .ready_o(rdy[0]), .state_i(sti[0]),
`ifdef PL_ITER_LANE_MASK_EN
        .lane_mask_i(mski[0]),
`endif
        .valid_o(vo[0]), .ready_i(rin[0]), .diffusion_o(dif[0]), .busy_o(bsy[0])
    );

    pl_iter #(.LANES_PER_CYCLE(5)) u_l5 (
        .clock_i(clk), .resetb_i(resetb), .valid_i(vin[1]), .ready_o(rdy[1]), .state_i(sti[1]),
`ifdef PL_ITER_LANE_MASK_EN
        .lane_mask_i(mski[1]),
`endif
        .valid_o(vo[1]), .ready_i(rin[1]), .diffusion_o(dif[1]), .busy_o(bsy[1])
    );

    pl_iter #(.LANES_PER_CYCLE(2)) u_l2 (
        .clock_i(clk), .resetb_i(resetb), .valid_i(vin[2]), .ready_o(rdy[2]), .state_i(sti[2]),
`ifdef PL_ITER_LANE_MASK_EN
        .lane_mask_i(mski[2]),
`endif
        .valid_o(vo[2]), .ready_i(rin[2]), .diffusion_o(dif[2]), .busy_o(bsy[2])
    );

    task automatic check_val(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_rotr(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] model(input logic [319:0] s, input logic [4:0] m);
        int          ra [5];
        int          rb [5];
        logic [319:0] r;
        logic [63:0]  x;
        ra = '{19, 61, 1, 10, 7};
        rb = '{28, 39, 6, 17, 41};
        r  = s;
        for (int k = 0; k < 5; k++) begin
            x = s[64*k +: 64];
            if (m[k]) r[64*k +: 64] = x ^ m_rotr(x, ra[k]) ^ m_rotr(x, rb[k]);
        end
        return r;
    endfunction

    task automatic run_txn(input int d, input string tag, input logic [319:0] st, input logic [4:0] m,
                           input int lat, input logic [319:0] exp);
        int n;
        @(negedge clk);
        vin[d]  = 1'b1;
        sti[d]  = st;
        mski[d] = m;
        #1;
        check_val({tag, "_ready_idle"}, rdy[d], 1'b1);
        @(posedge clk);
        #1;
        vin[d] = 1'b0;
        check_val({tag, "_busy_run"}, bsy[d], 1'b1);
        check_val({tag, "_ready_run"}, rdy[d], 1'b0);
        n = 0;
        while (!vo[d] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val({tag, "_latency"}, n, lat);
        check_val({tag, "_data"}, dif[d], exp);
    endtask

    task automatic release_out(input int d, input string tag);
        @(negedge clk);
        rin[d] = 1'b1;
        @(posedge clk);
        #1;
        rin[d] = 1'b0;
        check_val({tag, "_valid_drop"}, vo[d], 1'b0);
        check_val({tag, "_ready_back"}, rdy[d], 1'b1);
        check_val({tag, "_busy_drop"}, bsy[d], 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [319:0] s;
        logic [319:0] res;
        logic         saw_v;
        for (int d = 0; d < 3; d++) begin
            vin[d] = 1'b0; rin[d] = 1'b0; sti[d] = '0; mski[d] = 5'h1F;
        end
        resetb = 1'b1;
        #1 resetb = 1'b0;
        #2;
        check_val("rst_diff", dif[0], '0);
        check_val("rst_valid", vo[0], 1'b0);
        check_val("rst_busy", bsy[0], 1'b0);
        check_val("rst_ready", rdy[0], 1'b1);
        repeat (2) @(negedge clk);
        resetb = 1'b1;

        // Lane 2 = 1 through the one-lane engine.
        run_txn(0, "l1_lane2", {64'h0, 64'h0, 64'h1, 64'h0, 64'h0}, 5'h1F, 5,
                {64'h0, 64'h0, 64'h8400_0000_0000_0001, 64'h0, 64'h0});
        release_out(0, "l1_lane2");

        run_txn(0, "l1_lane0", {64'h0, 64'h0, 64'h0, 64'h0, 64'h1}, 5'h1F, 5,
                {64'h0, 64'h0, 64'h0, 64'h0, 64'h0000_2010_0000_0001});
        release_out(0, "l1_lane0");

        run_txn(1, "l5_ones", {5{64'hFFFF_FFFF_FFFF_FFFF}}, 5'h1F, 1, {5{64'hFFFF_FFFF_FFFF_FFFF}});
        release_out(1, "l5_ones");

        s = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001,
             64'hDEAD_BEEF_CAFE_F00D, 64'h0F0F_0F0F_5555_AAAA};
        run_txn(1, "l5_mixed", s, 5'h1F, 1, model(s, 5'h1F));
        release_out(1, "l5_mixed");

        s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_txn(2, "l2_rand", s, 5'h1F, 3, model(s, 5'h1F));

        // Hold the result for ten cycles while a new offer toggles on valid_i.
        res = dif[2];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vin[2] = i[0];
            sti[2] = ~s;
            @(posedge clk);
            #1;
            check_val("bp_diff_stable", dif[2], res);
            check_val("bp_ready_low", rdy[2], 1'b0);
            check_val("bp_valid_high", vo[2], 1'b1);
        end
        @(negedge clk);
        vin[2] = 1'b0;
        release_out(2, "l2_bp");
        check_val("bp_no_second_accept", dif[2], res);

        s = {64'h1, 64'h2, 64'h4, 64'h8, 64'h10};
        run_txn(2, "l2_after_bp", s, 5'h1F, 3, model(s, 5'h1F));
        release_out(2, "l2_after_bp");

        // Reset pulse in the middle of a one-lane run.
        @(negedge clk);
        vin[0] = 1'b1;
        sti[0] = {64'h5, 64'h6, 64'h7, 64'h8, 64'h9};
        @(posedge clk);
        #1 vin[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 resetb = 1'b0;
        #1;
        check_val("arst_diff", dif[0], '0);
        check_val("arst_valid", vo[0], 1'b0);
        check_val("arst_busy", bsy[0], 1'b0);
        check_val("arst_ready", rdy[0], 1'b1);
        @(negedge clk);
        resetb = 1'b1;
        saw_v = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (vo[0]) saw_v = 1'b1;
        end
        check_val("arst_no_valid", saw_v, 1'b0);

        s = {64'hAAAA_0000_FFFF_1234, 64'h1, 64'h0, 64'h0, 64'h8000_0000_0000_0000};
        run_txn(0, "l1_post_rst", s, 5'h1F, 5, model(s, 5'h1F));
        release_out(0, "l1_post_rst");

`ifdef PL_ITER_LANE_MASK_EN
        run_txn(0, "l1_mask", {64'h0, 64'h0, 64'h1, 64'h1, 64'h1}, 5'b00101, 5,
                {64'h0, 64'h0, 64'h8400_0000_0000_0001, 64'h1, 64'h0000_2010_0000_0001});
        release_out(0, "l1_mask");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
